// File: rtl/fifo_push_arb.sv
// Two-requester round-robin push arbiter in front of the shared FIFO.
// Bursts are bounded to BURST words per grant; FULLP stalls without rotating.
module fifo_push_arb #(
    parameter int DW    = 32,
    parameter int BURST = 4
) (
    input  logic          CLKP,
    input  logic          RSTNP,
    input  logic          REQ0P,
    input  logic [DW-1:0] DAT0P,
    output logic          ACK0P,
    input  logic          REQ1P,
    input  logic [DW-1:0] DAT1P,
    output logic          ACK1P,
    input  logic          FULLP,
    output logic          PUSHP,
    output logic [DW-1:0] DIP,
    output logic [1:0]    GNTP,
    output logic          BUSYP
);

    localparam int CW = (BURST > 1) ? $clog2(BURST + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_n;
    logic          last_r;
    logic          last_n;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n;
    logic          push_s;

    // Grant chosen from IDLE: a tie goes to the requester that was not served last.
    function automatic state_t pick_grant(input logic r0, input logic r1, input logic last);
        state_t g;
        if (r0 && r1) begin
            g = last ? G0 : G1;
        end else if (r0) begin
            g = G0;
        end else if (r1) begin
            g = G1;
        end else begin
            g = IDLE;
        end
        return g;
    endfunction

    // State, last-served pointer and burst counter registers.
    always_ff @(posedge CLKP) begin
        if (!RSTNP) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_n;
            last_r  <= last_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state logic: grant, burst rotation and request-drop handling.
    always_comb begin
        state_n = state_r;
        last_n  = last_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                if (REQ0P || REQ1P) begin
                    state_n = pick_grant(REQ0P, REQ1P, last_r);
                    last_n  = (pick_grant(REQ0P, REQ1P, last_r) == G1);
                    cnt_n   = CNT_ZERO;
                end else begin
                    state_n = IDLE;
                end
            end
            G0: begin
                if (!REQ0P) begin
                    cnt_n = CNT_ZERO;
                    if (REQ1P) begin
                        state_n = G1;
                        last_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (push_s) begin
                    if (cnt_r == CNT_LAST) begin
                        // Burst done: hand over only if the other side waits.
                        cnt_n = CNT_ZERO;
                        if (REQ1P) begin
                            state_n = G1;
                            last_n  = 1'b1;
                        end else begin
                            state_n = G0;
                        end
                    end else begin
                        cnt_n = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end
            G1: begin
                if (!REQ1P) begin
                    cnt_n = CNT_ZERO;
                    if (REQ0P) begin
                        state_n = G0;
                        last_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (push_s) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_n = CNT_ZERO;
                        if (REQ0P) begin
                            state_n = G0;
                            last_n  = 1'b0;
                        end else begin
                            state_n = G1;
                        end
                    end else begin
                        cnt_n = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end
            default: begin
                state_n = IDLE;
                last_n  = 1'b1;
                cnt_n   = CNT_ZERO;
            end
        endcase
    end

    // Outputs decoded from state; push is gated by FULLP in the same cycle.
    always_comb begin
        push_s = 1'b0;
        PUSHP  = 1'b0;
        ACK0P  = 1'b0;
        ACK1P  = 1'b0;
        GNTP   = 2'b00;
        BUSYP  = 1'b0;
        DIP    = {DW{1'b0}};
        case (state_r)
            G0: begin
                push_s = REQ0P & ~FULLP;
                PUSHP  = push_s;
                ACK0P  = push_s;
                GNTP   = 2'b01;
                BUSYP  = 1'b1;
                DIP    = DAT0P;
            end
            G1: begin
                push_s = REQ1P & ~FULLP;
                PUSHP  = push_s;
                ACK1P  = push_s;
                GNTP   = 2'b10;
                BUSYP  = 1'b1;
                DIP    = DAT1P;
            end
            default: begin
                push_s = 1'b0;
                PUSHP  = 1'b0;
                GNTP   = 2'b00;
                BUSYP  = 1'b0;
                DIP    = {DW{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Bench for fifo_push_arb: directed scenarios plus random traffic, with a
// per-requester word scoreboard and an arbitration-order queue.
module tb_fifo_push_arb;
    localparam int DW    = 32;
    localparam int BURST = 4;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic          full = 1'b0;
    logic [DW-1:0] dat0 = '0;
    logic [DW-1:0] dat1 = '0;
    logic          ack0, ack1, push, busy;
    logic [DW-1:0] dip;
    logic [1:0]    gnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] src0[$];
    logic [31:0] src1[$];
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          ord_q[$];

    logic h0 = 1'b0;
    logic h1 = 1'b0;
    logic ack0_seen = 1'b0;
    logic ack1_seen = 1'b0;
    int   tpush = 0;
    int   tfirst = 0;
    int   tlast = 0;
    int   cyc = 0;
    int   w0 = 0;
    int   w1 = 0;

    always #5 clk = ~clk;

    fifo_push_arb #(.DW(DW), .BURST(BURST)) dut (
        .CLKP (clk),
        .RSTNP(rstn),
        .REQ0P(req0),
        .DAT0P(dat0),
        .ACK0P(ack0),
        .REQ1P(req1),
        .DAT1P(dat1),
        .ACK1P(ack1),
        .FULLP(full),
        .PUSHP(push),
        .DIP  (dip),
        .GNTP (gnt),
        .BUSYP(busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive();
        req0 = (src0.size() > 0) && !h0;
        dat0 = (src0.size() > 0) ? src0[0] : 32'h0;
        req1 = (src1.size() > 0) && !h1;
        dat1 = (src1.size() > 0) ? src1[0] : 32'h0;
    endtask

    // One clock: retire words acknowledged at the edge, then re-drive.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (ack0_seen && src0.size() > 0) void'(src0.pop_front());
        if (ack1_seen && src1.size() > 0) void'(src1.pop_front());
        drive();
    endtask

    task automatic enq(input int who, input logic [31:0] w);
        if (who == 0) begin
            src0.push_back(w);
            exp0.push_back(w);
        end else begin
            src1.push_back(w);
            exp1.push_back(w);
        end
        drive();
    endtask

    task automatic do_reset();
        h0 = 1'b0;
        h1 = 1'b0;
        full = 1'b0;
        rstn = 1'b0;
        cycle();
        cycle();
        #1;
        check("rst_out", 32'({gnt, push, busy, ack0, ack1}), 32'h0);
        check("rst_dip", dip, 32'h0);
        rstn = 1'b1;
        tpush = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((src0.size() > 0 || src1.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain", 32'(src0.size() + src1.size()), 32'h0);
        if (src0.size() > 0 || src1.size() > 0) begin
            src0.delete();
            src1.delete();
            exp0.delete();
            exp1.delete();
            ord_q.delete();
            drive();
        end
    endtask

    task automatic stats(input int n, input int span);
        check("count", 32'(tpush), 32'(n));
        check("span", 32'(tlast - tfirst + 1), 32'(span));
    endtask

    // Monitor: scoreboard, arbitration order, fairness bound and invariants.
    initial begin
        int who;
        forever begin
            @(negedge clk);
            cyc++;
            ack0_seen = ack0;
            ack1_seen = ack1;
            check("excl", 32'({gnt == 2'b11, ack0 & ack1, push & full}), 32'h0);
            check("ack_push", 32'(ack0 | ack1), 32'(push));
            if (gnt == 2'b00) check("idle_out", 32'({push, busy, dip != 32'h0}), 32'h0);
            if (gnt[0] && req0 && !full) check("stall0", 32'(push), 32'h1);
            if (gnt[1] && req1 && !full) check("stall1", 32'(push), 32'h1);
            if (!req1 || !rstn) w0 = 0;
            if (!req0 || !rstn) w1 = 0;
            if (push) begin
                who = ack1 ? 1 : 0;
                if (who == 0) begin
                    if (exp0.size() > 0) check("data0", dip, exp0.pop_front());
                    else check("extra0", 32'h1, 32'h0);
                    if (req1) w0++;
                    w1 = 0;
                    check("fair0", 32'(w0 <= BURST), 32'h1);
                end else begin
                    if (exp1.size() > 0) check("data1", dip, exp1.pop_front());
                    else check("extra1", 32'h1, 32'h0);
                    if (req0) w1++;
                    w0 = 0;
                    check("fair1", 32'(w1 <= BURST), 32'h1);
                end
                if (ord_q.size() > 0) check("order", 32'(who), 32'(ord_q.pop_front()));
                if (tpush == 0) tfirst = cyc;
                tlast = cyc;
                tpush++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single requester, three words, first push one cycle after request.
        ord_q = '{0, 0, 0};
        enq(0, 32'h11000011);
        enq(0, 32'h22000022);
        enq(0, 32'h33000033);
        cycle();
        #1;
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_push", 32'(push), 32'h1);
        check("t1_dip", dip, 32'h11000011);
        wait_done(50);
        cycle();
        #1;
        check("t1_busy", 32'({busy, gnt}), 32'h0);
        stats(3, 3);

        // Both requesters, six words each: 4/4/2/2 with a bubble only on the drop.
        do_reset();
        ord_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            enq(0, 32'hA0000000 + 32'(i));
            enq(1, 32'hB0000000 + 32'(i));
        end
        cycle();
        #1;
        check("t2_first", 32'(gnt), 32'h1);
        wait_done(100);
        stats(12, 13);

        // FULLP stall for three cycles after word 2 of a burst.
        do_reset();
        ord_q = '{0, 0, 0, 0, 1, 1, 0, 0};
        for (int i = 1; i <= 6; i++) enq(0, 32'hD0000000 + 32'(i));
        enq(1, 32'hE0000001);
        enq(1, 32'hE0000002);
        for (int n = 0; n < 20 && src0.size() > 4; n++) cycle();
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall", 32'({push, ack0}), 32'h0);
            check("t3_gnt", 32'(gnt), 32'h1);
            cycle();
        end
        full = 1'b0;
        #1;
        check("t3_resume", 32'(push), 32'h1);
        check("t3_dip", dip, 32'hD0000003);
        wait_done(100);

        // One requester, nine words: continuous pushes across burst wraps.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            ord_q.push_back(1);
            enq(1, 32'hC0000000 + 32'(i));
        end
        cycle();
        #1;
        check("t4_gnt", 32'(gnt), 32'h2);
        wait_done(100);
        stats(9, 9);

        // Reset mid-burst, then a tie goes to requester 0.
        do_reset();
        for (int i = 0; i < 6; i++) enq(1, 32'h50000000 + 32'(i));
        cycle();
        cycle();
        rstn = 1'b0;
        cycle();
        #1;
        check("t5_rst", 32'({push, gnt, busy}), 32'h0);
        rstn = 1'b1;
        enq(0, 32'h60000000);
        enq(0, 32'h60000001);
        cycle();
        #1;
        check("t5_tie", 32'(gnt), 32'h1);
        wait_done(100);

        // Requester 0 drops after one ACK while requester 1 waits.
        do_reset();
        enq(0, 32'h70000000);
        enq(1, 32'h80000000);
        enq(1, 32'h80000001);
        enq(1, 32'h80000002);
        cycle();
        #1;
        check("t6_g0", 32'({gnt, push}), 32'h3);
        cycle();
        #1;
        check("t6_drop", 32'(push), 32'h0);
        cycle();
        #1;
        check("t6_g1", 32'({gnt, push}), 32'h5);
        check("t6_dip", dip, 32'h80000000);
        wait_done(100);

        // Random traffic with back-pressure and transient request withdrawal.
        for (int i = 0; i < 1500; i++) begin
            full = ($urandom_range(0, 3) == 0);
            h0 = ($urandom_range(0, 9) == 0);
            h1 = ($urandom_range(0, 9) == 0);
            if (src0.size() < 3 && $urandom_range(0, 1) == 1) enq(0, $urandom);
            if (src1.size() < 3 && $urandom_range(0, 1) == 1) enq(1, $urandom);
            drive();
            cycle();
        end
        h0 = 1'b0;
        h1 = 1'b0;
        full = 1'b0;
        drive();
        wait_done(300);
        cycle();
        cycle();
        check("exp_empty", 32'(exp0.size() + exp1.size()), 32'h0);
        check("ord_empty", 32'(ord_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
